// File: rtl/turbo_rx_fsm.sv
// Turbo receive frame controller: tracks K data beats plus 3 tail beats, forwards
// systematic bits and checks parity 1 / termination by re-running constituent encoder 1.
module turbo_rx_fsm #(
  parameter int unsigned K_LONG  = 6,
  parameter int unsigned K_SHORT = 4,
  parameter int unsigned CNT_W   = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic       rx_start,
  input  logic       rx_sys,
  input  logic       rx_p1,
  input  logic       rx_p2,
  input  logic       length_flag,
  output logic       dout_valid,
  output logic       dout,
  output logic       dout_p2,
  output logic       dout_last,
  output logic       frame_done,
  output logic [7:0] parity_err_cnt,
  output logic       tail_err,
  output logic       sync_err,
  output logic       busy,
  output logic [2:0] current_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TAIL = 3'd2,
    DATA = 3'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [2:0]       s_q, s_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_q, dout_d;
  logic             dout_p2_q, dout_p2_d;
  logic             dout_last_q, dout_last_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       perr_q, perr_d;
  logic             tail_err_q, tail_err_d;
  logic             sync_err_q, sync_err_d;

  logic [CNT_W-1:0] k_sel, k_cur, cnt_cur;
  logic [2:0]       s_cur;
  logic [7:0]       perr_base;
  logic             data_beat, fb, zb, tail_z, tail_x;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    s_d          = s_q;
    dout_valid_d = 1'b0;
    dout_d       = 1'b0;
    dout_p2_d    = 1'b0;
    dout_last_d  = 1'b0;
    frame_done_d = 1'b0;
    perr_d       = perr_q;
    tail_err_d   = tail_err_q;
    sync_err_d   = 1'b0;
    k_sel        = length_flag ? CNT_W'(K_LONG) : CNT_W'(K_SHORT);
    k_cur        = k_q;
    cnt_cur      = cnt_q;
    s_cur        = s_q;
    perr_base    = perr_q;
    data_beat    = 1'b0;
    fb           = 1'b0;
    zb           = 1'b0;
    tail_x       = s_q[1] ^ s_q[2];
    tail_z       = s_q[0] ^ s_q[2];

    if (rx_valid) begin
      if (rx_start) begin
        // A start in any state restarts the frame; the data path below sees a fresh context.
        sync_err_d = (state_q != IDLE);
        k_d        = k_sel;
        k_cur      = k_sel;
        cnt_cur    = '0;
        s_cur      = '0;
        perr_base  = '0;
        tail_err_d = 1'b0;
        data_beat  = 1'b1;
      end else if (state_q == DATA) begin
        data_beat = 1'b1;
      end else if (state_q == TAIL) begin
        if ((rx_sys != tail_x) || (rx_p1 != tail_z)) begin
          tail_err_d = 1'b1;
        end
        s_d = {s_q[1:0], 1'b0};
        if (cnt_q == CNT_W'(2)) begin
          cnt_d        = '0;
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (data_beat) begin
      fb           = rx_sys ^ s_cur[1] ^ s_cur[2];
      zb           = fb ^ s_cur[0] ^ s_cur[2];
      s_d          = {s_cur[1:0], fb};
      perr_d       = ((zb != rx_p1) && (perr_base != 8'hFF)) ? perr_base + 8'd1 : perr_base;
      dout_valid_d = 1'b1;
      dout_d       = rx_sys;
      dout_p2_d    = rx_p2;
      dout_last_d  = (cnt_cur == k_cur - CNT_W'(1));
      if (cnt_cur == k_cur - CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = TAIL;
      end else begin
        cnt_d   = cnt_cur + CNT_W'(1);
        state_d = DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      s_q          <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= 1'b0;
      dout_p2_q    <= 1'b0;
      dout_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      perr_q       <= '0;
      tail_err_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      s_q          <= s_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_p2_q    <= dout_p2_d;
      dout_last_q  <= dout_last_d;
      frame_done_q <= frame_done_d;
      perr_q       <= perr_d;
      tail_err_q   <= tail_err_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout_valid     = dout_valid_q;
  assign dout           = dout_q;
  assign dout_p2        = dout_p2_q;
  assign dout_last      = dout_last_q;
  assign frame_done     = frame_done_q;
  assign parity_err_cnt = perr_q;
  assign tail_err       = tail_err_q;
  assign sync_err       = sync_err_q;
  assign busy           = (state_q != IDLE);
  assign current_state  = state_q;

endmodule

// File: tb/tb_turbo_rx_fsm.sv
// Self-checking bench for turbo_rx_fsm: frame-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized beat streams.
module tb_turbo_rx_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_valid = 1'b0, rx_start = 1'b0, rx_sys = 1'b0, rx_p1 = 1'b0, rx_p2 = 1'b0;
  logic       length_flag = 1'b0;
  logic       dout_valid, dout, dout_p2, dout_last, frame_done, tail_err, sync_err, busy;
  logic [7:0] parity_err_cnt;
  logic [2:0] current_state;

  turbo_rx_fsm #(.K_LONG(6), .K_SHORT(4), .CNT_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_start(rx_start),
    .rx_sys(rx_sys), .rx_p1(rx_p1), .rx_p2(rx_p2), .length_flag(length_flag),
    .dout_valid(dout_valid), .dout(dout), .dout_p2(dout_p2), .dout_last(dout_last),
    .frame_done(frame_done), .parity_err_cnt(parity_err_cnt), .tail_err(tail_err),
    .sync_err(sync_err), .busy(busy), .current_state(current_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 data, 2 tail; enc holds encoder memory (enc[0] newest).
  int         phase = 0, idx = 0, klen = 0, e_perr = 0;
  logic [2:0] enc = '0;
  logic       e_dv = 0, e_d = 0, e_dp2 = 0, e_dl = 0, e_fd = 0, e_se = 0, e_terr = 0;
  logic       fbk, par, isdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase = 0; idx = 0; klen = 0; e_perr = 0; enc = '0;
      e_dv = 0; e_d = 0; e_dp2 = 0; e_dl = 0; e_fd = 0; e_se = 0; e_terr = 0;
    end else begin
      e_dv = 0; e_d = 0; e_dp2 = 0; e_dl = 0; e_fd = 0; e_se = 0;
      isdata = 0;
      if (rx_valid) begin
        if (rx_start) begin
          e_se = (phase != 0);
          klen = length_flag ? 6 : 4;
          e_perr = 0; e_terr = 0; enc = '0; idx = 0;
          isdata = 1;
        end else if (phase == 1) begin
          isdata = 1;
        end else if (phase == 2) begin
          par = enc[0] ^ enc[2];
          if (rx_sys != (enc[1] ^ enc[2]) || rx_p1 != par) e_terr = 1;
          enc = {enc[1], enc[0], 1'b0};
          idx++;
          if (idx == 3) begin phase = 0; idx = 0; e_fd = 1; end
        end
      end
      if (isdata) begin
        fbk = rx_sys ^ enc[1] ^ enc[2];
        par = fbk ^ enc[0] ^ enc[2];
        enc = {enc[1], enc[0], fbk};
        if (par != rx_p1 && e_perr < 255) e_perr++;
        e_dv = 1; e_d = rx_sys; e_dp2 = rx_p2; e_dl = (idx == klen - 1);
        idx++;
        if (idx == klen) begin phase = 2; idx = 0; end
        else phase = 1;
      end
    end
  end

  // Capture of downstream activity for the directed literal checks.
  logic [15:0] cap = '0;
  int cap_n = 0, fd_cnt = 0, sync_cnt = 0, fd_perr = 0;
  logic fd_terr = 0;

  always @(negedge clk) begin
    chk("current_state", current_state, phase == 1 ? 3 : (phase == 2 ? 2 : 0));
    chk("busy", busy, phase != 0);
    chk("dout_valid", dout_valid, e_dv);
    if (e_dv) begin
      chk("dout", dout, e_d);
      chk("dout_p2", dout_p2, e_dp2);
      chk("dout_last", dout_last, e_dl);
    end
    chk("frame_done", frame_done, e_fd);
    chk("sync_err", sync_err, e_se);
    chk("parity_err_cnt", parity_err_cnt, e_perr);
    chk("tail_err", tail_err, e_terr);
    if (dout_valid) begin cap = {cap[14:0], dout}; cap_n++; end
    if (frame_done) begin fd_cnt++; fd_perr = parity_err_cnt; fd_terr = tail_err; end
    if (sync_err) sync_cnt++;
  end

  task automatic beat(input logic v, input logic st, input logic s, input logic p1,
                      input logic p2, input logic lf);
    rx_valid = v; rx_start = st; rx_sys = s; rx_p1 = p1; rx_p2 = p2; length_flag = lf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, 0);
  endtask

  // Bits are MSB-first; length_flag flips after the start beat; stop_at cuts the frame short.
  task automatic run_frame(input logic lf, input int n, input logic [7:0] sv, input logic [7:0] pv,
                           input logic [2:0] ts, input logic [2:0] tp, input int gap_at,
                           input int stop_at);
    int sent;
    sent = 0;
    for (int i = 0; i < n; i++) begin
      if (stop_at >= 0 && sent == stop_at) return;
      beat(1, i == 0, sv[n-1-i], pv[n-1-i], 1'($urandom), i == 0 ? lf : ~lf);
      sent++;
      if (i == gap_at) begin
        beat(0, 0, 1, 1, 1, lf);
        beat(0, 1, 1, 0, 1, ~lf);
      end
    end
    for (int j = 0; j < 3; j++) begin
      if (stop_at >= 0 && sent == stop_at) return;
      beat(1, 0, ts[2-j], tp[2-j], 1'($urandom), ~lf);
      sent++;
    end
  endtask

  int fd0, sy0, cn0;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", current_state, 0);
    chk("reset_perr", parity_err_cnt, 0);
    reset_n = 1'b1;
    idle(2);

    // K=4 clean frame
    fd0 = fd_cnt; cn0 = cap_n;
    run_frame(0, 4, 8'b1011, 8'b1101, 3'b000, 3'b000, -1, -1);
    idle(1);
    chk("t1_bits", int'(cap[3:0]), 4'b1011);
    chk("t1_count", cap_n - cn0, 4);
    chk("t1_done", fd_cnt - fd0, 1);
    chk("t1_perr", fd_perr, 0);
    chk("t1_terr", fd_terr, 0);

    // parity-1 flip on bit 2
    run_frame(0, 4, 8'b1011, 8'b1111, 3'b000, 3'b000, -1, -1);
    idle(1);
    chk("t2_perr", fd_perr, 1);
    chk("t2_terr", fd_terr, 0);

    // plus tail beat 2 p1 wrong
    run_frame(0, 4, 8'b1011, 8'b1111, 3'b000, 3'b010, -1, -1);
    idle(1);
    chk("t3_perr", fd_perr, 1);
    chk("t3_terr", fd_terr, 1);

    // K=6 with gap after bit 2 and length_flag toggling
    fd0 = fd_cnt; cn0 = cap_n;
    run_frame(1, 6, 8'b110100, 8'($urandom), 3'($urandom), 3'($urandom), 2, -1);
    idle(1);
    chk("t4_count", cap_n - cn0, 6);
    chk("t4_bits", int'(cap[5:0]), 6'b110100);
    chk("t4_done", fd_cnt - fd0, 1);

    // back-to-back frames, second one clean
    fd0 = fd_cnt;
    run_frame(0, 4, 8'b1011, 8'b1111, 3'b000, 3'b010, -1, -1);
    run_frame(0, 4, 8'b1011, 8'b1101, 3'b000, 3'b000, -1, -1);
    idle(1);
    chk("t5_done", fd_cnt - fd0, 2);
    chk("t5_perr", fd_perr, 0);
    chk("t5_terr", fd_terr, 0);
    chk("t5_bits", int'(cap[7:0]), 8'b10111011);

    // restart at data bit 2
    fd0 = fd_cnt; sy0 = sync_cnt; cn0 = cap_n;
    run_frame(0, 4, 8'b1011, 8'b1101, 3'b000, 3'b000, -1, 2);
    run_frame(0, 4, 8'b1011, 8'b1101, 3'b000, 3'b000, -1, -1);
    idle(1);
    chk("t6_sync", sync_cnt - sy0, 1);
    chk("t6_done", fd_cnt - fd0, 1);
    chk("t6_count", cap_n - cn0, 6);
    chk("t6_perr", fd_perr, 0);

    // asynchronous reset during tail
    fd0 = fd_cnt;
    run_frame(0, 4, 8'b1011, 8'b1111, 3'b000, 3'b000, -1, 5);
    chk("t7_pre_state", current_state, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_state", current_state, 0);
    chk("t7_rst_perr", parity_err_cnt, 0);
    chk("t7_rst_outs", {dout_valid, dout, dout_p2, dout_last, frame_done, tail_err, sync_err, busy}, 0);
    rx_valid = 0; rx_start = 0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 4, 8'b1011, 8'b1101, 3'b000, 3'b000, -1, -1);
    idle(1);
    chk("t7_done", fd_cnt - fd0, 1);
    chk("t7_bits", int'(cap[3:0]), 4'b1011);
    chk("t7_perr", fd_perr, 0);

    // randomized beat stream
    for (int i = 0; i < 1500; i++) begin
      beat(($urandom % 5) != 0,
           (phase == 0) ? 1'($urandom) : (($urandom % 40) == 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
